// File: rtl/lcd_bus_driver_if.sv
// Request strobes from the LCD message generators plus the HD44780 pin bundle.
interface lcd_bus_driver_if;
    logic       wr;
    logic       dr;
    logic [7:0] dbi;
    logic [7:0] direc;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       busy;
    logic       init_done;
    logic       ovf;

    modport master (output wr, dr, dbi, direc,
                    input  lcd_e, lcd_rs, lcd_rw, lcd_db, busy, init_done, ovf);
    modport slave  (input  wr, dr, dbi, direc,
                    output lcd_e, lcd_rs, lcd_rw, lcd_db, busy, init_done, ovf);
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 write engine: turns wr/dr strobes into timed E/RS/DB cycles with a one-deep slot.
// Define LCD_INIT_EN to add the power-on wait and the 0x38/0x0C/0x06/0x01 init sequence.
module lcd_bus_driver #(
    parameter int T_POWERUP = 300000,
    parameter int T_AS      = 2,
    parameter int T_PW      = 10,
    parameter int T_H       = 2,
    parameter int T_EXEC    = 800,
    parameter int T_CLR     = 33000,
    parameter int CNT_W     = 19
) (
    input  logic            clk,
    input  logic            rst,
    lcd_bus_driver_if.slave bus
);

    typedef enum logic [2:0] {INIT_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC_WAIT} state_t;

    localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_PW   = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_H    = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_CLR  = CNT_W'(T_CLR - 1);

`ifdef LCD_INIT_EN
    localparam bit               INIT_EN   = 1'b1;
    localparam state_t           RST_STATE = INIT_WAIT;
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_POWERUP - 1);
`else
    localparam bit               INIT_EN   = 1'b0;
    localparam state_t           RST_STATE = IDLE;
    localparam logic [CNT_W-1:0] RST_CNT   = {CNT_W{1'b0}};
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_wr_q, r_dr_q;
    logic             r_slot_vld, w_slot_vld_nxt;
    logic [8:0]       r_slot, w_slot_nxt;
    logic             r_lcd_e;
    logic             r_lcd_rs, w_rs_nxt;
    logic [7:0]       r_lcd_db, w_db_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [1:0]       r_init_idx, w_init_idx_nxt;
    logic             r_init_done, w_init_done_nxt;
    logic             w_wr_edge, w_dr_edge, w_cnt_zero;
    logic             w_start, w_take_slot, w_used_dr, w_used_wr, w_slot_free;
    logic [8:0]       w_start_req;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Clear and home commands need the long execution wait.
    function automatic logic [CNT_W-1:0] exec_load(input logic rs, input logic [7:0] b);
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
            exec_load = LD_CLR;
        else
            exec_load = LD_EXEC;
    endfunction

    assign w_wr_edge  = bus.wr & ~r_wr_q;
    assign w_dr_edge  = bus.dr & ~r_dr_q;
    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_slot_vld_nxt  = r_slot_vld;
        w_slot_nxt      = r_slot;
        w_rs_nxt        = r_lcd_rs;
        w_db_nxt        = r_lcd_db;
        w_ovf_nxt       = r_ovf;
        w_init_idx_nxt  = r_init_idx;
        w_init_done_nxt = r_init_done;
        w_start         = 1'b0;
        w_start_req     = 9'd0;
        w_take_slot     = 1'b0;
        w_used_dr       = 1'b0;
        w_used_wr       = 1'b0;
        w_slot_free     = 1'b0;

        case (r_state)
            INIT_WAIT: begin
                if (w_cnt_zero) begin
                    w_start     = 1'b1;
                    w_start_req = {1'b0, init_cmd(2'd0)};
                end
            end
            IDLE: begin
                if (r_slot_vld) begin
                    w_take_slot = 1'b1;
                    w_start     = 1'b1;
                    w_start_req = r_slot;
                end else if (w_dr_edge) begin
                    w_used_dr   = 1'b1;
                    w_start     = 1'b1;
                    w_start_req = {1'b0, bus.direc};
                end else if (w_wr_edge) begin
                    w_used_wr   = 1'b1;
                    w_start     = 1'b1;
                    w_start_req = {1'b1, bus.dbi};
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = LD_PW;
                end
            end
            PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LD_H;
                end
            end
            HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = EXEC_WAIT;
                    w_cnt_nxt   = exec_load(r_lcd_rs, r_lcd_db);
                end
            end
            EXEC_WAIT: begin
                if (w_cnt_zero) begin
                    if (!r_init_done && r_init_idx != 2'd3) begin
                        w_init_idx_nxt = r_init_idx + 2'd1;
                        w_start        = 1'b1;
                        w_start_req    = {1'b0, init_cmd(r_init_idx + 2'd1)};
                    end else begin
                        w_init_done_nxt = 1'b1;
                        if (r_slot_vld) begin
                            w_take_slot = 1'b1;
                            w_start     = 1'b1;
                            w_start_req = r_slot;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase

        if (w_start) begin
            w_state_nxt = SETUP;
            w_cnt_nxt   = LD_AS;
            w_rs_nxt    = w_start_req[8];
            w_db_nxt    = w_start_req[7:0];
        end
        if (w_take_slot)
            w_slot_vld_nxt = 1'b0;

        // Requests that did not start directly queue behind the slot, dr ahead of wr.
        w_slot_free = !r_slot_vld || w_take_slot;
        if (w_dr_edge && !w_used_dr) begin
            if (w_slot_free) begin
                w_slot_vld_nxt = 1'b1;
                w_slot_nxt     = {1'b0, bus.direc};
                w_slot_free    = 1'b0;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
        if (w_wr_edge && !w_used_wr) begin
            if (w_slot_free) begin
                w_slot_vld_nxt = 1'b1;
                w_slot_nxt     = {1'b1, bus.dbi};
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RST_STATE;
            r_cnt       <= RST_CNT;
            r_wr_q      <= 1'b0;
            r_dr_q      <= 1'b0;
            r_slot_vld  <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_db    <= 8'h00;
            r_ovf       <= 1'b0;
            r_init_idx  <= 2'd0;
            r_init_done <= !INIT_EN;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wr_q      <= bus.wr;
            r_dr_q      <= bus.dr;
            r_slot_vld  <= w_slot_vld_nxt;
            r_lcd_e     <= (w_state_nxt == PULSE);
            r_lcd_rs    <= w_rs_nxt;
            r_lcd_db    <= w_db_nxt;
            r_ovf       <= w_ovf_nxt;
            r_init_idx  <= w_init_idx_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Slot payload is only meaningful while r_slot_vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        r_slot <= w_slot_nxt;
    end

    assign bus.lcd_e     = r_lcd_e;
    assign bus.lcd_rs    = r_lcd_rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_db    = r_lcd_db;
    assign bus.busy      = !(r_state == IDLE && !r_slot_vld && r_init_done);
    assign bus.init_done = r_init_done;
    assign bus.ovf       = r_ovf;

endmodule
